// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32x32 multiply / divide unit with HI/LO registers.
// Multiply is radix-2 shift-add and divide is restoring. Each takes 32 CALC
// cycles, then one FIX cycle that applies sign correction and writes HI/LO.
// Handshake: start is sampled only in IDLE. busy is high whenever the FSM is
// not IDLE. done pulses for one cycle, in the first cycle HI/LO show the result.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        whi,
    input  logic        wlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mag_a_q, mag_a_d;   // multiplicand, or dividend shifting out MSB-first
    logic [31:0] mag_b_q, mag_b_d;   // multiplier shifting out LSB-first, or divisor
    logic [1:0]  op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        b_zero_q, b_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // op[0]=0 selects the signed variants; op[1]=1 selects divide.
    logic        is_signed_in;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic        neg_res;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign is_signed_in = ~op[0];
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (mag_b_q[0] ? mag_a_q : 32'd0)};
    assign div_diff = {acc_q[63:32], mag_a_q[31]} - {1'b0, mag_b_q};
    assign neg_res  = ~op_q[0] & (sign_a_q ^ sign_b_q);
    assign prod_fix = neg_res ? (~acc_q + 64'd1) : acc_q;
    assign quot_fix = neg_res ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    // State register; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; cancel aborts to IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !cancel) state_d = S_CALC;
            S_CALC:  if (cancel) state_d = S_IDLE;
                     else if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    // Datapath next-state: operand latch, iteration step, result write-back.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        hi_d     = whi ? wdata : hi_q;
        lo_d     = wlo ? wdata : lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    op_d     = op;
                    sign_a_d = is_signed_in & A[31];
                    sign_b_d = is_signed_in & B[31];
                    mag_a_d  = (is_signed_in & A[31]) ? (~A + 32'd1) : A;
                    mag_b_d  = (is_signed_in & B[31]) ? (~B + 32'd1) : B;
                    b_zero_d = (B == 32'd0);
                    acc_d    = 64'd0;
                    cnt_d    = 5'd0;
                end
            end
            S_CALC: begin
                if (!cancel) begin
                    cnt_d = cnt_q + 5'd1;
                    if (!op_q[1]) begin
                        acc_d   = {mul_sum, acc_q[31:1]};
                        mag_b_d = {1'b0, mag_b_q[31:1]};
                    end else begin
                        // A non-negative trial difference means the divisor fits.
                        if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
                        else               acc_d = {acc_q[62:32], mag_a_q[31], acc_q[30:0], 1'b0};
                        mag_a_d = {mag_a_q[30:0], 1'b0};
                    end
                end
            end
            S_FIX: begin
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (b_zero_q) begin
                        // Divide by zero leaves remainder=|A|, so restoring A's sign returns A.
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = rem_fix;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            op_q     <= 2'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 and the iteration count at 32.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 A  in  32  rs operand (multiplicand or dividend).
REQ-007 B  in  32  rt operand (multiplier or divisor).
REQ-008 cancel  in  1  pipeline flush; aborts any operation in flight.
REQ-009 whi  in  1  MTHI write enable.
REQ-010 wlo  in  1  MTLO write enable.
REQ-011 wdata  in  32  MTHI/MTLO data.
REQ-012 busy  out  1  operation in flight; the pipeline stalls MFHI/MFLO and new mult/div on it.
REQ-013 done  out  1  one-cycle pulse; asserted in the cycle in which hi/lo first hold the new result.
REQ-014 hi  out  32  HI register (product[63:32] or remainder).
REQ-015 lo  out  32  LO register (product[31:0] or quotient).

Function
REQ-016 The block SHALL implement the FSM IDLE -> CALC -> FIX -> IDLE with a 5-bit iteration counter.
REQ-017 IDLE and start=1 and cancel=0: latch op, the signs of A and B, and the magnitudes (|A| and |B| for signed ops, raw values for unsigned ops); clear the 64-bit accumulator; counter=0; next state CALC.
REQ-018 CALC multiply: 1 radix-2 shift-add step per cycle over 32 cycles, using an unsigned 33-bit add.
REQ-019 CALC divide: 1 restoring step per cycle using a 33-bit trial subtract; quotient bit = 1 when the difference is non-negative.
REQ-020 CALC: when counter=31, counter wraps to 0 and next state = FIX.
REQ-021 FIX: apply sign correction and write hi/lo; next state IDLE; done=1 on the following cycle only.
  - product: negated when signA^signB=1 (signed ops only).
  - quotient: negated when signA^signB=1 (signed ops only).
  - remainder: takes the sign of A (signed ops only).
REQ-022 Latency SHALL be fixed:
  - start sampled at edge 0;
  - busy=1 from cycle 1 through cycle 33 (busy=1 iff state != IDLE);
  - hi/lo updated and done=1 in cycle 34.
  - Back-to-back: a new start is accepted in the done cycle.
REQ-023 start while busy=1 SHALL be ignored; it is neither queued nor errored.
REQ-024 Division by zero (B=0, DIV or DIVU) SHALL still take 34 cycles, bypass sign correction, and produce lo=32'hFFFF_FFFF, hi=A.
REQ-025 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL produce lo=32'h8000_0000, hi=0, with no exception.
REQ-026 cancel=1 SHALL force IDLE on the next edge with hi/lo unchanged and no done pulse.
  - cancel has priority over start in the same cycle.
REQ-027 whi/wlo SHALL write hi/lo on the next edge in any state.
  - In the FIX cycle, the operation result wins over whi/wlo.
  - whi/wlo together with start in IDLE: the write applies and the operation proceeds normally.
REQ-028 Operands SHALL be latched at start; A/B changes during CALC do not affect the result.

Reset
REQ-029 rst=1 SHALL set on the next edge: state=IDLE, counter=0, accumulator=0, hi=0, lo=0, busy=0, done=0.
REQ-030 rst SHALL override start, cancel, whi and wlo.
  - rst mid-operation discards the operation; no done pulse is produced.
  - Normal operation resumes on the first edge after rst deasserts.

Verification
REQ-031 MULT A=-3 (32'hFFFF_FFFD), B=7 -> done at cycle 34; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; busy=1 over cycles 1-33.
REQ-032 MULTU A=B=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-033 DIV A=-7, B=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
  - DIVU A=7, B=0 -> lo=32'hFFFF_FFFF, hi=7.
REQ-034 Hazard and priority sequence:
  - start MULTU 5*5, then start DIVU pulsed at cycle 10 -> ignored; result hi=0, lo=25.
  - wlo=1, wdata=9 at cycle 33 (FIX) -> lo=25.
  - wlo=1, wdata=9 in the done cycle -> lo=9 one cycle later.
REQ-035 Abort sequence:
  - DIV started with hi=lo=32'h1234_5678; cancel at cycle 20 -> IDLE at cycle 21, hi/lo unchanged, no done.
  - Repeat with rst at cycle 20 -> hi=lo=0.
  - A new start is accepted immediately after each abort.
